// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage register.
//   PAYLOAD_W_DEFAULT : default payload width (PC, PC+1, instruction as 16+16+16)
//   stage_state_e     : occupancy state of the two-entry stage
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PAYLOAD_W_DEFAULT = 48;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage : pipe_pkg

// File: rtl/pipeline_stage_reg.sv
// ---------------------------------------------------------------------------
// pipeline_stage_reg
// Two-entry valid/ready pipeline register (main + skid). It is a drop-in
// replacement for fixed-width IF/ID-style registers. in_ready is decoded
// from the state register only, so there is no combinational path from
// out_ready to in_ready.
//
// Parameters
//   DATA_W         : payload width
//   CLEAR_ON_FLUSH : 1 = flush zeroes main/skid, 0 = flush keeps their value
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset (overrides flush)
//   flush      in   discard all held entries and any incoming one
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept a payload this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a valid payload
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  payload from the main register
//   occupancy  out  entries held: 0, 1 or 2
// ---------------------------------------------------------------------------
module pipeline_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = PAYLOAD_W_DEFAULT,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_e      state_reg;
    stage_state_e      state_next;
    logic [DATA_W-1:0] main_reg;
    logic [DATA_W-1:0] main_next;
    logic [DATA_W-1:0] skid_reg;
    logic [DATA_W-1:0] skid_next;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

    // Next-state and payload steering.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;

        unique case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    state_next = ONE;
                    main_next  = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_next = in_data;
                end else if (in_fire) begin
                    state_next = FULL;
                    skid_next  = in_data;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so in_fire cannot occur.
                if (out_fire) begin
                    state_next = ONE;
                    main_next  = skid_reg;
                end
            end
            default: begin
                // Unreachable encoding: recover to an empty stage.
                state_next = EMPTY;
            end
        endcase

        // Flush wins over both handshakes; the payload either clears or
        // keeps its pre-flush contents, never the contents loaded above.
        if (flush) begin
            state_next = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_next = '0;
                skid_next = '0;
            end else begin
                main_next = main_reg;
                skid_next = skid_reg;
            end
        end
    end

    // Outputs decoded from the state register only.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
        unique case (state_reg)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    assign out_data = main_reg;

endmodule : pipeline_stage_reg

// File: tb/tb_pipeline_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stage_reg
// Two instances share the stimulus: dut_c (CLEAR_ON_FLUSH=1) and dut_n
// (CLEAR_ON_FLUSH=0). A queue-based model of the stage is stepped on every
// rising edge; a compare process checks both instances against it on every
// falling edge. Directed sequences also pin literal expected values.
// ---------------------------------------------------------------------------
module tb_pipeline_stage_reg;

    localparam int W = 48;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;

    logic         in_ready_c, out_valid_c;
    logic [W-1:0] out_data_c;
    logic [1:0]   occ_c;
    logic         in_ready_n, out_valid_n;
    logic [W-1:0] out_data_n;
    logic [1:0]   occ_n;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: FIFO contents plus the value each variant shows when empty.
    logic [W-1:0] mq[$];
    logic [W-1:0] res_c = '0;
    logic [W-1:0] res_n = '0;

    always #5 clk = ~clk;

    pipeline_stage_reg #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b1)) dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .occupancy(occ_c)
    );

    pipeline_stage_reg #(.DATA_W(W), .CLEAR_ON_FLUSH(1'b0)) dut_n (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
        .occupancy(occ_n)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endtask

    // Model update on each rising edge from the inputs seen at that edge.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                res_c = '0;
                res_n = '0;
            end else if (flush) begin
                if (mq.size() > 0) res_n = mq[0];
                res_c = '0;
                mq.delete();
            end else begin
                bit do_in;
                bit do_out;
                do_in  = in_valid && (mq.size() < 2);
                do_out = (mq.size() > 0) && out_ready;
                if (do_out) begin
                    res_c = mq.pop_front();
                    res_n = res_c;
                end
                if (do_in) mq.push_back(in_data);
            end
        end
    end

    // Compare process: both instances against the model every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic [W-1:0] exp_c;
                logic [W-1:0] exp_n;
                exp_c = (mq.size() > 0) ? mq[0] : res_c;
                exp_n = (mq.size() > 0) ? mq[0] : res_n;
                check("c_out_valid", W'(out_valid_c), W'(mq.size() > 0));
                check("c_in_ready",  W'(in_ready_c),  W'(mq.size() < 2));
                check("c_occupancy", W'(occ_c),       W'(mq.size()));
                check("c_out_data",  out_data_c,      exp_c);
                check("n_out_valid", W'(out_valid_n), W'(mq.size() > 0));
                check("n_in_ready",  W'(in_ready_n),  W'(mq.size() < 2));
                check("n_occupancy", W'(occ_n),       W'(mq.size()));
                check("n_out_data",  out_data_n,      exp_n);
            end
        end
    end

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic r, input logic f, input logic iv,
                       input logic [W-1:0] d, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
        $display("cyc t=%0t rst=%0b flush=%0b iv=%0b d=0x%0h ordy=%0b -> ov=%0b od=0x%0h occ=%0d ir=%0b",
                 $time, r, f, iv, d, ordy, out_valid_c, out_data_c, occ_c, in_ready_c);
    endtask

    initial begin
        // Reset then idle.
        cyc(1, 0, 0, '0, 0);
        chk_en = 1'b1;
        check("rst_out_valid", W'(out_valid_c), '0);
        check("rst_occupancy", W'(occ_c), '0);
        check("rst_out_data",  out_data_c, '0);
        check("rst_in_ready",  W'(in_ready_c), W'(1));
        cyc(0, 0, 0, '0, 0);

        // Streaming at full rate.
        cyc(0, 0, 1, 48'h1, 1);
        check("stream1_data", out_data_c, 48'h1);
        check("stream1_occ",  W'(occ_c), W'(1));
        cyc(0, 0, 1, 48'h2, 1);
        check("stream2_data", out_data_c, 48'h2);
        check("stream2_occ",  W'(occ_c), W'(1));
        cyc(0, 0, 1, 48'h3, 1);
        check("stream3_data", out_data_c, 48'h3);
        check("stream3_occ",  W'(occ_c), W'(1));
        cyc(0, 0, 0, '0, 1);
        check("stream_drain_valid", W'(out_valid_c), '0);

        // Backpressure fills skid, then drains in order.
        cyc(0, 0, 1, 48'hA, 0);
        cyc(0, 0, 1, 48'hB, 0);
        check("bp_occ",      W'(occ_c), W'(2));
        check("bp_in_ready", W'(in_ready_c), '0);
        check("bp_hold",     out_data_c, 48'hA);
        cyc(0, 0, 1, 48'hD, 0);
        check("bp_ignore_occ", W'(occ_c), W'(2));
        check("bp_hold2",      out_data_c, 48'hA);
        cyc(0, 0, 0, '0, 1);
        check("bp_second", out_data_c, 48'hB);
        check("bp_ready",  W'(in_ready_c), W'(1));
        check("bp_occ1",   W'(occ_c), W'(1));
        cyc(0, 0, 0, '0, 1);
        check("bp_empty", W'(out_valid_c), '0);

        // Simultaneous in/out while ONE.
        cyc(0, 0, 1, 48'h5, 0);
        check("sim_main", out_data_c, 48'h5);
        cyc(0, 0, 1, 48'h6, 1);
        check("sim_next", out_data_c, 48'h6);
        check("sim_occ",  W'(occ_c), W'(1));
        cyc(0, 0, 0, '0, 1);

        // Flush with a concurrent push.
        cyc(0, 0, 1, 48'hA, 0);
        cyc(0, 0, 1, 48'hB, 0);
        cyc(0, 1, 1, 48'hC, 1);
        check("fl_occ",    W'(occ_c), '0);
        check("fl_valid",  W'(out_valid_c), '0);
        check("fl_data_c", out_data_c, '0);
        check("fl_data_n", out_data_n, 48'hA);
        check("fl_valid_n", W'(out_valid_n), '0);
        cyc(0, 0, 0, '0, 1);
        check("fl_no_c_valid", W'(out_valid_c), '0);
        check("fl_no_c_data",  out_data_n, 48'hA);

        // Reset beats flush.
        cyc(0, 0, 1, 48'h11, 0);
        cyc(0, 0, 1, 48'h22, 0);
        cyc(1, 1, 1, 48'h33, 1);
        check("rf_occ",    W'(occ_c), '0);
        check("rf_data_c", out_data_c, '0);
        check("rf_data_n", out_data_n, '0);
        check("rf_ready",  W'(in_ready_n), W'(1));

        // Pseudo-random traffic checked by the model.
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(99) == 0), ($urandom_range(29) == 0),
                1'($urandom_range(1)), {$urandom, 16'($urandom)},
                ($urandom_range(3) != 0));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipeline_stage_reg

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 Parameter DATA_W, default 48, SHALL set payload width (PC, PC+1, instruction packed as 16+16+16).
REQ-002 Parameter CLEAR_ON_FLUSH, default 1, SHALL select whether flush zeroes stored payload (1) or leaves it unchanged (0).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 Port flush  input  1  SHALL discard all held entries when high.
REQ-006 Port in_valid  input  1  SHALL mark in_data as valid from the upstream stage.
REQ-007 Port in_ready  output  1  SHALL indicate the stage accepts in_data this cycle.
REQ-008 Port in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-009 Port out_valid  output  1  SHALL mark out_data as valid to the downstream stage.
REQ-010 Port out_ready  input  1  SHALL indicate downstream accepts out_data this cycle.
REQ-011 Port out_data  output  DATA_W  SHALL carry the held payload.
REQ-012 Port occupancy  output  2  SHALL report entries held (0, 1 or 2).

Function
REQ-013 Transfers SHALL occur only on in_valid&&in_ready (in-fire) or out_valid&&out_ready (out-fire).
REQ-014 Storage SHALL be a main register (drives out_data) plus one skid register; state EMPTY, ONE, FULL.
REQ-015 in_ready SHALL be a registered signal equal to (state != FULL), with no combinational path from out_ready.
REQ-016 out_valid SHALL be 1 exactly in ONE and FULL; out_data SHALL come from the main register only.
REQ-017 EMPTY: in-fire -> ONE, main <= in_data; otherwise stay.
REQ-018 ONE: in-fire and out-fire -> ONE, main <= in_data; in-fire only -> FULL, skid <= in_data; out-fire only -> EMPTY.
REQ-019 FULL: out-fire -> ONE, main <= skid; otherwise hold; in_valid ignored.
REQ-020 Latency in_data to out_data SHALL be 1 cycle when EMPTY, or ONE with out_ready=1; throughput SHALL be one transfer per cycle sustained.
REQ-021 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Data order SHALL be strictly FIFO; no entry duplicated or dropped except by flush/rst.
REQ-023 flush SHALL take priority over in-fire and out-fire: next state EMPTY, and any in-fire that cycle is discarded.
REQ-024 With CLEAR_ON_FLUSH=1, flush SHALL zero main and skid registers; with 0 they SHALL hold value.
REQ-025 occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL, registered.

Reset
REQ-026 rst SHALL override flush and all handshakes.
REQ-027 On the edge with rst=1: state EMPTY, main and skid zero, out_valid=0, occupancy=0, in_ready=1 on the following cycle.
REQ-028 Reset asserted mid-transfer SHALL discard all held and incoming payload with no partial update.

Structure
REQ-029 Package pipe_pkg SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and default payload width constant 48.
REQ-030 The block SHALL be a single module with no sub-modules; it replaces fixed-width IF/ID-style registers by instantiation per stage.

Verification
REQ-031 Reset: rst=1 one cycle, then idle -> out_valid=0, occupancy=0, out_data=0, in_ready=1.
REQ-032 Streaming: in_valid=1, out_ready=1, data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each, occupancy stays 1.
REQ-033 Backpressure: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB delivered, in_ready=1 after first out-fire.
REQ-034 Flush priority: FULL with 0xA/0xB, flush=1 with in_valid=1 data 0xC -> next cycle occupancy 0, out_valid=0, out_data=0; 0xC never appears.
REQ-035 Simultaneous in/out in ONE: main=0x5, in 0x6, out_ready=1 -> 0x5 consumed, out_data=0x6, occupancy 1.
REQ-036 Reset over flush: FULL, rst=1 and flush=1 together -> reset values per REQ-027; CLEAR_ON_FLUSH=0 flush-only case keeps out_data=0xA with out_valid=0.
